// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains a synchronous FIFO whose read data is registered (valid one cycle
// after rd_en) and presents the words on a valid/ready stream. A 2-entry
// output buffer hides the FIFO read latency so that one word per cycle flows
// under continuous m_ready. A flush pulse discards buffered and in-flight
// words and drains the FIFO; counters report delivered and dropped words.
//
// Ports
//   clk, rst_n    : clock, synchronous active-low reset (shared with FIFO)
//   fifo_empty    : FIFO empty flag
//   fifo_rd_data  : FIFO registered read data
//   fifo_rd_en    : FIFO read request (combinational)
//   m_valid/m_data/m_ready : output stream
//   flush         : single-cycle pulse, discard everything and drain FIFO
//   busy          : high while a flush is in progress
//   words_out     : completed output handshakes, wraps
//   drop_cnt      : discarded words, saturates at all-ones
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] words_out,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_FLUSH  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [CNT_W-1:0] words_out_q, words_out_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             pop;
  logic [2:0]       fill_after_pop;  // occ + inflight - pop
  logic [1:0]       occ_after_pop;
  logic [2:0]       drop_add;
  logic [CNT_W+1:0] drop_sum;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_STREAM;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STREAM: if (flush) state_d = ST_FLUSH;
      // Leave only once nothing is left in the FIFO or on the read pipe.
      ST_FLUSH:  if (fifo_empty && !inflight_q) state_d = ST_STREAM;
      default:   state_d = ST_STREAM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    m_valid        = (occ_q != 2'd0);
    m_data         = slot0_q;
    busy           = (state_q == ST_FLUSH);
    pop            = m_valid && m_ready;
    // pop implies occ >= 1, so this never underflows.
    fill_after_pop = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        // Issue a read only if its word is guaranteed a free slot on arrival;
        // the flush cycle itself never reads since that word would be dropped.
        ST_STREAM: fifo_rd_en = !fifo_empty && !flush && (fill_after_pop < 3'd2);
        ST_FLUSH:  fifo_rd_en = !fifo_empty;
        default:   fifo_rd_en = 1'b0;
      endcase
    end
  end

  assign words_out = words_out_q;
  assign drop_cnt  = drop_cnt_q;

  // ---------------------------------------------------------------------------
  // Buffer and counter next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    occ_d         = occ_q;
    slot0_d       = slot0_q;
    slot1_d       = slot1_q;
    words_out_d   = words_out_q;
    drop_add      = 3'd0;
    occ_after_pop = occ_q - {1'b0, pop};

    // A handshake in the flush cycle still counts as delivered.
    if (pop) words_out_d = words_out_q + CNT_W'(1);

    if (state_q == ST_FLUSH) begin
      if (inflight_q) drop_add = 3'd1;
    end else if (flush) begin
      occ_d    = 2'd0;
      drop_add = fill_after_pop;
    end else begin
      // Shift the head out first, then place the arriving word in the first
      // free slot; this keeps FIFO order with a simultaneous pop and capture.
      if (pop) slot0_d = slot1_q;
      if (inflight_q) begin
        if (occ_after_pop == 2'd0) slot0_d = fifo_rd_data;
        else                       slot1_d = fifo_rd_data;
      end
      occ_d = occ_after_pop + {1'b0, inflight_q};
    end

    drop_sum = {2'b00, drop_cnt_q} + (CNT_W+2)'(drop_add);
    if (drop_sum[CNT_W+1:CNT_W] != 2'b00) drop_cnt_d = '1;
    else                                  drop_cnt_d = drop_sum[CNT_W-1:0];
  end

  // NOTE: the data slots are reset as well because m_data is required to read
  // zero out of reset; they are only two registers, not a memory array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      words_out_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      occ_q       <= occ_d;
      inflight_q  <= fifo_rd_en;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      words_out_q <= words_out_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter that drains a synchronous FIFO with registered read data and presents its words on a valid/ready stream. It sits between the FIFO read port (`rd_en`/`empty`/`rd_data`) and a downstream consumer. It hides the FIFO's one-cycle read latency behind a 2-entry output buffer, so throughput is one word per cycle under continuous `m_ready`. It also provides a flush mechanism and observability counters.

## Interface
- `WIDTH`, 8, data word width; must equal the FIFO word width.
- `CNT_W`, 16, width of `words_out` and `drop_cnt`.
- `clk` in 1: single clock, shared with the FIFO.
- `rst_n` in 1: reset, synchronous, active-low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_data` in WIDTH: FIFO registered read data, valid the cycle after an accepted read.
- `fifo_rd_en` out 1: FIFO read request; combinational.
- `m_valid` out 1: output word valid.
- `m_data` out WIDTH: output word.
- `m_ready` in 1: consumer accepts the word when high together with `m_valid`.
- `flush` in 1: single-cycle pulse; discard all buffered data and drain the FIFO.
- `busy` out 1: high while a flush is in progress.
- `words_out` out CNT_W: count of completed output handshakes; wraps modulo 2^CNT_W.
- `drop_cnt` out CNT_W: count of discarded words; saturates at all-ones.

## Operation
- **State machine:** STREAM (reset state) and FLUSH.
  - STREAM → FLUSH when `flush` is sampled high.
  - FLUSH → STREAM when `fifo_empty` = 1 and `inflight` = 0 in the same cycle.
  - `flush` sampled while in FLUSH is ignored.
- **Internal state:**
  - `occ` (0..2): count of valid entries in the 2-entry buffer.
  - `slot0` is the head, `slot1` is the tail.
  - `inflight` (1 bit): registered copy of `fifo_rd_en`, meaning a read was issued last cycle.
- **Outputs from state:** `m_valid = (occ != 0)` and `m_data = slot0`.
- **Read request:** `pop = m_valid && m_ready`.
  - In STREAM: `fifo_rd_en = !fifo_empty && (occ + inflight - pop < 2)`.
  - In FLUSH: `fifo_rd_en = !fifo_empty`.
  - `fifo_rd_en` is forced to 0 while `rst_n` = 0 and in the cycle `flush` is sampled.
- **Invariant:** `occ + inflight <= 2` at all times. A capture into a full buffer is impossible, and the bench asserts it.
- **Capture:** in STREAM with `inflight` = 1, `fifo_rd_data` is written to the tail.
  - If a pop occurs in the same cycle, the buffer shifts first (`slot1` → `slot0`) and the new word goes to the first free slot.
  - `occ` net change = capture − pop.
- **Flush entry:**
  - `occ` ← 0 and `inflight` data is discarded.
  - `drop_cnt` += `occ + inflight` (saturating).
  - A pop in the flush cycle still completes and counts in `words_out`; it is not counted as a drop.
- **In FLUSH:** every word arriving with `inflight` = 1 is discarded and `drop_cnt` += 1. `m_valid` stays 0.
- **Writer during flush:** if the writer keeps writing, FLUSH persists. Writers must pause until `busy` falls.
- **Ordering:** words leave in FIFO order, with no loss or duplication outside flush.
- **`m_data` stability:** `m_data` is stable while `m_valid` = 1 and `m_ready` = 0.

## Timing
- **Reset values:** `m_valid` 0, `m_data` 0, `busy` 0, `words_out` 0, `drop_cnt` 0, `occ` 0, `inflight` 0, state STREAM.
- **Read latency:** with `fifo_rd_en` high in cycle t, `fifo_rd_data` is valid in t+1, is captured at the end of t+1, and `m_valid` rises in t+2.
- **End-to-end latency:** a FIFO write at the end of cycle w gives `fifo_empty` low in w+1, `fifo_rd_en` in w+1, and `m_valid` in w+3.
- **Throughput:** with continuous `m_ready` and a non-empty FIFO, the block sustains one word per cycle (steady state `occ` = 1, `inflight` = 1).
- **Backpressure:** with `m_ready` = 0, at most 2 words are pulled from the FIFO beyond those already delivered.
- **Flush timing:**
  - `flush` in cycle f gives `busy` high and `m_valid` low from f+1.
  - `busy` falls the cycle after the exit condition is met.
- **Reset mid-operation:**
  - Buffered and inflight words are lost and not counted.
  - The FIFO is reset by the same `rst_n`.
- **Counter rules:** `words_out` wraps to 0 after 2^CNT_W − 1; `drop_cnt` holds at all-ones.

## Test plan
- **Reset:** assert `rst_n` = 0 for 3 cycles with FIFO non-empty → `fifo_rd_en` = 0 throughout; all outputs 0 after release.
- **Single word:** write 0xA5, `m_ready` = 1 → one `fifo_rd_en` pulse; `m_valid` for exactly 1 cycle, 2 cycles after the read, with `m_data` = 0xA5; `words_out` = 1.
- **Streaming:** write 0x00..0x0F, `m_ready` = 1 → 16 consecutive `m_valid` cycles with data 0x00..0x0F in order; `words_out` = 16.
- **Backpressure:** FIFO holds 5 words, `m_ready` = 0 for 10 cycles → exactly 2 reads issued and `m_data` = word0 stable. Then `m_ready` = 1 → words 0..4 in order, no duplicates.
- **Flush:** `occ` = 2 and FIFO holds 4 with the writer idle, pulse `flush` → `m_valid` 0 and `busy` high; FIFO drained; `drop_cnt` = 6; `busy` low once empty; the next write streams normally.
- **Saturation/wrap:** with `CNT_W` = 4, stream 17 words → `words_out` = 1. Drop 20 words across flushes → `drop_cnt` = 15.
